fp_mul_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking, round-to-nearest-even and full special-value handling. It is the next-generation multiplier for the PE datapath: configurable exponent/mantissa width and pipeline depth, lossless stall under backpressure, and IEEE exception flags per result. Default configuration is binary16, matching the existing PE accumulate path.

---
 rtl/fp_mul_pkg.sv | 37 +++
 rtl/fp_mul_pipe_mant.sv | 28 ++
 rtl/fp_mul_pipe.sv | 169 ++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Widths are supplied by the caller so one package serves every format.
package fp_mul_pkg;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_W         = 4;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // {0, all-ones exponent, fraction MSB set}; callers keep the low 1+exp_w+man_w bits.
   function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
   endfunction

   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic frac_zero);
      if (exp_zero)
         return FP_ZERO;
      else if (exp_ones)
         return frac_zero ? FP_INF : FP_NAN;
      else
         return FP_NORM;
   endfunction

endpackage

// File: rtl/fp_mul_pipe_mant.sv
// Unsigned significand multiplier followed by a stall-able register chain;
// the chain gives synthesis retiming room to spread the multiply array.
module fp_mant_mul_pipe #(
   parameter int SIG_W  = 11,
   parameter int STAGES = 4
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [SIG_W-1:0]     x,
   input  logic [SIG_W-1:0]     y,
   output logic [2*SIG_W-1:0]   p
);

   logic [2*SIG_W-1:0] pipe [STAGES];

   // NOTE: pure datapath registers carry no reset; the valid bits travelling
   // alongside them decide whether their contents mean anything.
   always_ff @(posedge clk) begin
      if (en) begin
         pipe[0] <= {{SIG_W{1'b0}}, x} * {{SIG_W{1'b0}}, y};
         for (int i = 1; i < STAGES; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   assign p = pipe[STAGES-1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier: classify at the input, carry the
// special-case sideband beside the significand product, round/pack at the end.
module fp_mul_pipe
   import fp_mul_pkg::*;
#(
   parameter int EXP_W   = 5,
   parameter int MAN_W   = 10,
   parameter int LATENCY = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1;
   localparam int PW    = 2 * SIG_W;
   localparam int EW    = EXP_W + 2;
   localparam int DEPTH = LATENCY - 1;

   localparam logic [EW-1:0]        BIAS_E     = EW'(fp_bias(EXP_W));
   localparam logic signed [EW-1:0] EXP_MAX    = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO   = '0;
   localparam logic [63:0]          CANON_FULL = fp_canon_nan(EXP_W, MAN_W);
   localparam logic [W-1:0]         CANON_NAN  = CANON_FULL[W-1:0];

   typedef struct packed {
      logic                   sign;
      fp_class_e              cls;
      logic                   invalid;
      logic signed [EW-1:0]   exp;
   } side_t;

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic               sa, sb;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   fp_class_e          ca, cb;
   side_t              side_in;

   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;
   assign ca = fp_classify(ea == '0, &ea, fa == '0);
   assign cb = fp_classify(eb == '0, &eb, fb == '0);

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      side_in.sign    = sa ^ sb;
      side_in.cls     = FP_NORM;
      side_in.invalid = 1'b0;
      side_in.exp     = {2'b00, ea} + {2'b00, eb} - BIAS_E;
      if (ca == FP_NAN || cb == FP_NAN) begin
         side_in.cls = FP_NAN;
      end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
         side_in.cls     = FP_NAN;
         side_in.invalid = 1'b1;
      end else if (ca == FP_INF || cb == FP_INF) begin
         side_in.cls = FP_INF;
      end else if (ca == FP_ZERO || cb == FP_ZERO) begin
         side_in.cls = FP_ZERO;
      end
   end

   logic [PW-1:0] prod;

   fp_mant_mul_pipe #(
      .SIG_W  (SIG_W),
      .STAGES (DEPTH)
   ) u_mant (
      .clk (clk),
      .en  (en),
      .x   ({1'b1, fa}),
      .y   ({1'b1, fb}),
      .p   (prod)
   );

   side_t side_q [DEPTH];
   logic  vld_q  [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            vld_q[i] <= 1'b0;
      end else if (en) begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++)
            vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         side_q[0] <= side_in;
         for (int i = 1; i < DEPTH; i++)
            side_q[i] <= side_q[i-1];
      end
   end

   side_t                sd;
   logic [PW-2:0]        norm;
   logic [MAN_W-1:0]     frac;
   logic                 guard, sticky, inc;
   logic [MAN_W:0]       frac_r;
   logic signed [EW-1:0] e_fin;
   logic [W-1:0]         res_d;
   logic [3:0]           flags_d;

   assign sd = side_q[DEPTH-1];

   // norm drops the leading one; the product is in [1,4) so at most one shift is needed.
   always_comb begin
      norm    = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      frac    = norm[PW-2 -: MAN_W];
      guard   = norm[MAN_W];
      sticky  = |norm[MAN_W-1:0];
      inc     = guard & (sticky | frac[0]);
      frac_r  = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
      e_fin   = sd.exp + EW'(prod[PW-1]) + EW'(frac_r[MAN_W]);
      res_d   = '0;
      flags_d = '0;
      case (sd.cls)
         FP_NAN: begin
            res_d                 = CANON_NAN;
            flags_d[FLAG_INVALID] = sd.invalid;
         end
         FP_INF:  res_d = {sd.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         FP_ZERO: res_d = {sd.sign, {(W-1){1'b0}}};
         default: begin
            if (e_fin >= EXP_MAX) begin
               res_d                  = {sd.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d[FLAG_OVERFLOW] = 1'b1;
               flags_d[FLAG_INEXACT]  = 1'b1;
            end else if (e_fin <= EXP_ZERO) begin
               res_d                   = {sd.sign, {(W-1){1'b0}}};
               flags_d[FLAG_UNDERFLOW] = 1'b1;
               flags_d[FLAG_INEXACT]   = 1'b1;
            end else begin
               res_d                 = {sd.sign, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
               flags_d[FLAG_INEXACT] = guard | sticky;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (en) begin
         out_valid <= vld_q[DEPTH-1];
         if (vld_q[DEPTH-1]) begin
            result <= res_d;
            flags  <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed and randomised-backpressure checks of fp_mul_pipe (binary16 and
// an EXP_W=8/MAN_W=7 build) against hand-computed values and an integer model.
module tb_fp_mul_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [3:0]  flags;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [15:0] a8, b8, result8;
   logic [3:0]  flags8;

   int checks   = 0;
   int failures = 0;

   fp_mul_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .LATENCY(5)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .result    (result8),
      .flags     (flags8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Independent binary16 reference: integer product rounded by remainder comparison.
   task automatic ref_mul(input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output logic [3:0] f);
      logic s, xn, yn, xi, yi, xz, yz;
      int   ex, ey, p, sh, e, q, rem, half;
      s  = x[15] ^ y[15];
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 31) && (x[9:0] == 0);
      yi = (ey == 31) && (y[9:0] == 0);
      xn = (ex == 31) && (x[9:0] != 0);
      yn = (ey == 31) && (y[9:0] != 0);
      f  = 4'b0000;
      if (xn || yn) begin
         r = 16'h7E00;
      end else if ((xi && yz) || (xz && yi)) begin
         r = 16'h7E00;
         f = 4'b1000;
      end else if (xi || yi) begin
         r = {s, 15'h7C00};
      end else if (xz || yz) begin
         r = {s, 15'h0000};
      end else begin
         p    = (1024 + int'(x[9:0])) * (1024 + int'(y[9:0]));
         sh   = (p >= (1 << 21)) ? 11 : 10;
         e    = ex + ey - 15 + (sh - 10);
         q    = p >> sh;
         rem  = p & ((1 << sh) - 1);
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && q[0]))
            q++;
         if (q == 2048) begin
            q = 1024;
            e++;
         end
         if (e >= 31) begin
            r = {s, 15'h7C00};
            f = 4'b0101;
         end else if (e <= 0) begin
            r = {s, 15'h0000};
            f = 4'b0011;
         end else begin
            r = {s, e[4:0], q[9:0]};
            f = {3'b000, rem != 0};
         end
      end
   endtask

   function automatic logic [15:0] gen_operand();
      logic [15:0] v;
      if ($urandom_range(0, 7) == 0) begin
         case ($urandom_range(0, 5))
            0:       v = 16'h0000;
            1:       v = 16'h8000;
            2:       v = 16'h7C00;
            3:       v = 16'hFC00;
            4:       v = 16'h7E55;
            default: v = 16'h0201;
         endcase
      end else begin
         v[15]    = 1'($urandom_range(0, 1));
         v[14:10] = 5'($urandom_range(1, 30));
         v[9:0]   = 10'($urandom_range(0, 1023));
      end
      return v;
   endfunction

   task automatic run_single(input logic [15:0] x, input logic [15:0] y,
                             output logic [15:0] r, output logic [3:0] f, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      r = result;
      f = flags;
   endtask

   task automatic vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] er, input logic [3:0] ef, input logic chk_lat);
      logic [15:0] r;
      logic [3:0]  f;
      int          lat;
      run_single(x, y, r, f, lat);
      check({tag, "_result"}, 32'(r), 32'(er));
      check({tag, "_flags"}, 32'(f), 32'(ef));
      if (chk_lat)
         check({tag, "_latency"}, 32'(lat), 32'd5);
   endtask

   initial begin
      logic [15:0] q_a, q_b, er, r8;
      logic [3:0]  ef;
      logic [19:0] exp_q [$];
      logic [19:0] exp_v;
      int          sent, recv, extra, cyc, seen, lat;

      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      a          = '0;
      b          = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      a8         = '0;
      b8         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags", 32'(flags), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      vec("one_x_two",     16'h3C00, 16'h4000, 16'h4000, 4'b0000, 1'b1);
      vec("norm_shift",    16'h3E00, 16'h3E00, 16'h4080, 4'b0000, 1'b1);
      vec("rne_down",      16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 1'b0);
      vec("rne_tie_even",  16'h3C01, 16'h3E00, 16'h3E02, 4'b0001, 1'b0);
      vec("inf_x_zero",    16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 1'b0);
      vec("neg_inf",       16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 1'b0);
      vec("nan_in",        16'h7E01, 16'h3C00, 16'h7E00, 4'b0000, 1'b0);
      vec("subnorm_flush", 16'h0001, 16'h7BFF, 16'h0000, 4'b0000, 1'b0);
      vec("overflow",      16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 1'b0);
      vec("underflow",     16'h0400, 16'h0400, 16'h0000, 4'b0011, 1'b0);
      vec("neg_zero",      16'h8000, 16'h4000, 16'h8000, 4'b0000, 1'b0);
      vec("neg_product",   16'hC000, 16'h4000, 16'hC400, 4'b0000, 1'b0);

      // Output held under backpressure, then released.
      @(negedge clk);
      in_valid  = 1'b1;
      a         = 16'h3C00;
      b         = 16'h4000;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc      = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      check("stall_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("stall_hold_valid", 32'(out_valid), 32'd1);
      check("stall_hold_result", 32'(result), 32'h4000);
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release", 32'(out_valid), 32'd0);

      // Random operands back to back with random out_ready.
      sent  = 0;
      recv  = 0;
      extra = 0;
      cyc   = 0;
      q_a   = gen_operand();
      q_b   = gen_operand();
      while ((sent < 100 || recv < sent) && cyc < 3000) begin
         @(negedge clk);
         in_valid  = (sent < 100);
         a         = q_a;
         b         = q_b;
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               extra++;
            end else begin
               exp_v = exp_q.pop_front();
               check("rand_result", 32'({flags, result}), 32'(exp_v));
               recv++;
            end
         end
         if (in_valid && in_ready) begin
            ref_mul(q_a, q_b, er, ef);
            exp_q.push_back({ef, er});
            sent++;
            q_a = gen_operand();
            q_b = gen_operand();
         end
         cyc++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("rand_received", 32'(recv), 32'd100);
      check("rand_extra", 32'(extra), 32'd0);
      repeat (8) begin
         @(negedge clk);
         if (out_valid)
            extra++;
      end
      check("rand_no_dup", 32'(extra), 32'd0);

      // Reset with three products in flight.
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1;
         a        = 16'h3C00;
         b        = 16'h4000;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_flush_now", 32'(out_valid), 32'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid)
            seen++;
      end
      check("rst_flush_after", 32'(seen), 32'd0);
      vec("post_reset", 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 1'b1);

      // EXP_W=8, MAN_W=7 build: 1.0 x 1.0.
      @(negedge clk);
      in_valid8 = 1'b1;
      a8        = 16'h3F80;
      b8        = 16'h3F80;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      lat       = 1;
      while (!out_valid8 && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      r8 = result8;
      check("bf16_result", 32'(r8), 32'h3F80);
      check("bf16_flags", 32'(flags8), 32'd0);
      check("bf16_latency", 32'(lat), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
